fetch_unit: RTL and testbench

Instruction-byte fetch stage sitting directly upstream of `controlpath`: owns the PC, reads method-area bytes through a req/ack memory port, and loads `MBR`, which `controlpath` consumes for JMPC dispatch. While a fetch is incomplete it raises `stall`, and the top level holds MPC/MIR on it. Sign- and zero-extended copies of `MBR` feed the B bus of the datapath.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - byte-wide req/ack memory read port of the fetch stage
//
// Purpose: groups the method-area read port between fetch_unit and memory.
// Signals:
//   mem_req    request held high until acknowledged (master -> slave)
//   mem_addr   byte address, stable while mem_req is high (master -> slave)
//   mem_rdata  read byte, valid while mem_ack is high (slave -> master)
//   mem_ack    single-cycle acknowledge, one per request (slave -> master)
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-byte fetch stage: PC, MBR and method-area reads
//
// Purpose: owns the PC, reads method-area bytes through a req/ack port and
// loads MBR for JMPC dispatch. stall is raised while the current fetch
// microinstruction cannot retire.
// Optional feature macro: FETCH_PREFETCH_EN adds a one-entry prefetch buffer
// and the WAIT_P state so sequential fetches complete without stalling.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fetch           fetch bit of the current MIR (level, held during stall)
//   pc_wr, pc_in    C-bus write of PC
//   mem             memory read port (fetch_unit_if.master)
//   PC              program counter
//   MBR             fetched byte
//   mbr_sext/zext   MBR sign/zero-extended to 32 bits
//   stall           combinational; fetch outstanding this cycle
module fetch_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic              pc_wr,
  input  logic [ADDR_W-1:0] pc_in,
  fetch_unit_if.master      mem,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        MBR,
  output logic [31:0]       mbr_sext,
  output logic [31:0]       mbr_zext,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_F = 2'd1,
    WAIT_P = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] faddr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic              req_q;
  logic              req_nx;
  logic              mbr_ld;
  logic [7:0]        mbr_nx;
  logic              done;
  logic              hit;

  // A same-cycle PC write and fetch targets the freshly written PC.
  assign faddr = pc_wr ? pc_in : PC;

`ifdef FETCH_PREFETCH_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              buf_ld;

  assign hit = buf_valid && (buf_addr == faddr);
`else
  assign hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fetch) state_nx = hit ? WAIT_P : WAIT_F;
      end
      WAIT_F: begin
`ifdef FETCH_PREFETCH_EN
        if (mem.mem_ack) state_nx = WAIT_P;
`else
        if (mem.mem_ack) state_nx = IDLE;
`endif
      end
      WAIT_P: begin
        if (mem.mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    done    = 1'b0;
    mbr_ld  = 1'b0;
    mbr_nx  = mem.mem_rdata;
    req_nx  = req_q;
    addr_nx = addr_q;
`ifdef FETCH_PREFETCH_EN
    buf_ld  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fetch) begin
          req_nx = 1'b1;
`ifdef FETCH_PREFETCH_EN
          if (hit) begin
            // Serve from the buffer and immediately prefetch the next byte.
            done    = 1'b1;
            mbr_ld  = 1'b1;
            mbr_nx  = buf_data;
            addr_nx = faddr + ADDR_W'(1);
          end else begin
            addr_nx = faddr;
          end
`else
          addr_nx = faddr;
`endif
        end
      end
      WAIT_F: begin
        if (mem.mem_ack) begin
          done   = 1'b1;
          mbr_ld = 1'b1;
`ifdef FETCH_PREFETCH_EN
          // Request stays up and moves on to the next sequential byte.
          req_nx  = 1'b1;
          addr_nx = addr_q + ADDR_W'(1);
`else
          req_nx = 1'b0;
`endif
        end
      end
      WAIT_P: begin
        if (mem.mem_ack) begin
          req_nx = 1'b0;
`ifdef FETCH_PREFETCH_EN
          buf_ld = 1'b1;
`endif
          // A fetch waiting on exactly this byte completes with the ack.
          if (fetch && (faddr == addr_q)) begin
            done   = 1'b1;
            mbr_ld = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign stall = fetch && !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC     <= '0;
      MBR    <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      if (pc_wr)  PC  <= pc_in;
      if (mbr_ld) MBR <= mbr_nx;
      req_q  <= req_nx;
      addr_q <= addr_nx;
    end
  end

`ifdef FETCH_PREFETCH_EN
  // The method area is read-only, so the buffer is only cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (buf_ld) begin
      buf_valid <= 1'b1;
      buf_addr  <= addr_q;
      buf_data  <= mem.mem_rdata;
    end
  end
`endif

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  assign mbr_sext = {{24{MBR[7]}}, MBR};
  assign mbr_zext = {24'b0, MBR};

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch;
  logic        pc_wr;
  logic [31:0] pc_in;
  logic [31:0] PC;
  logic [7:0]  MBR;
  logic [31:0] mbr_sext;
  logic [31:0] mbr_zext;
  logic        stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32)) mif ();

  fetch_unit #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch    (fetch),
    .pc_wr    (pc_wr),
    .pc_in    (pc_in),
    .mem      (mif),
    .PC       (PC),
    .MBR      (MBR),
    .mbr_sext (mbr_sext),
    .mbr_zext (mbr_zext),
    .stall    (stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    fetch         = 1'b0;
    pc_wr         = 1'b0;
    pc_in         = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    #12;
    check("rst_pc", PC, 32'h0);
    check("rst_mbr", {24'b0, MBR}, 32'h0);
    check("rst_req", {31'b0, mif.mem_req}, 32'h0);
    check("rst_addr", mif.mem_addr, 32'h0);
    check("rst_stall0", {31'b0, stall}, 32'h0);
    fetch = 1'b1;
    #1;
    check("rst_stall1", {31'b0, stall}, 32'h1);
    fetch = 1'b0;
    step();
    rst = 1'b0;

    // Reset in the middle of a demand read
    pc_wr = 1'b1; pc_in = 32'h30; fetch = 1'b1;
    step();
    pc_wr = 1'b0;
    check("t1_req", {31'b0, mif.mem_req}, 32'h1);
    check("t1_addr", mif.mem_addr, 32'h30);
    rst = 1'b1;
    #1;
    check("t1_req_rst", {31'b0, mif.mem_req}, 32'h0);
    check("t1_pc_rst", PC, 32'h0);
    check("t1_mbr_rst", {24'b0, MBR}, 32'h0);
    step();
    rst = 1'b0; fetch = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'hAB;
    step();
    mif.mem_ack = 1'b0;
    check("t1_late_ack_mbr", {24'b0, MBR}, 32'h0);
    check("t1_late_ack_req", {31'b0, mif.mem_req}, 32'h0);

    // Miss with three wait states
    pc_wr = 1'b1; pc_in = 32'h10;
    step();
    pc_wr = 1'b0;
    check("t2_pc", PC, 32'h10);
    fetch = 1'b1;
    #1;
    check("t2_stall_issue", {31'b0, stall}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_addr", mif.mem_addr, 32'h10);
      check("t2_stall_wait", {31'b0, stall}, 32'h1);
    end
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h85;
    #1;
    check("t2_stall_ack", {31'b0, stall}, 32'h0);
    step();
    mif.mem_ack = 1'b0; fetch = 1'b0;
    check("t2_mbr", {24'b0, MBR}, 32'h85);
    check("t2_sext", mbr_sext, 32'hFFFFFF85);
    check("t2_zext", mbr_zext, 32'h00000085);
`ifdef FETCH_PREFETCH_EN
    check("t2_pf_req", {31'b0, mif.mem_req}, 32'h1);
    check("t2_pf_addr", mif.mem_addr, 32'h11);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h86;
    step();
    mif.mem_ack = 1'b0;
`endif
    check("t2_req_done", {31'b0, mif.mem_req}, 32'h0);

    // Same-cycle PC write and fetch
    pc_wr = 1'b1; pc_in = 32'h21; fetch = 1'b1;
    #1;
    check("t3_stall", {31'b0, stall}, 32'h1);
    step();
    pc_wr = 1'b0;
    check("t3_addr", mif.mem_addr, 32'h21);
    check("t3_pc", PC, 32'h21);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h5A;
    step();
    mif.mem_ack = 1'b0; fetch = 1'b0;
    check("t3_mbr", {24'b0, MBR}, 32'h5A);

`ifdef FETCH_PREFETCH_EN
    // Sequential fetch served from the prefetch buffer
    check("t4_pf_addr", mif.mem_addr, 32'h22);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h7F;
    step();
    mif.mem_ack = 1'b0;
    check("t4_mbr_hold", {24'b0, MBR}, 32'h5A);
    pc_wr = 1'b1; pc_in = 32'h22; fetch = 1'b1;
    #1;
    check("t4_hit_stall", {31'b0, stall}, 32'h0);
    step();
    pc_wr = 1'b0; fetch = 1'b0;
    check("t4_mbr", {24'b0, MBR}, 32'h7F);
    check("t4_next_addr", mif.mem_addr, 32'h23);
    check("t4_next_req", {31'b0, mif.mem_req}, 32'h1);

    // Non-matching fetch while a prefetch is outstanding
    pc_wr = 1'b1; pc_in = 32'h40; fetch = 1'b1;
    #1;
    check("t5_stall_a", {31'b0, stall}, 32'h1);
    step();
    pc_wr = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h99;
    #1;
    check("t5_stall_b", {31'b0, stall}, 32'h1);
    step();
    mif.mem_ack = 1'b0;
    check("t5_mbr_kept", {24'b0, MBR}, 32'h7F);
    check("t5_req_idle", {31'b0, mif.mem_req}, 32'h0);
    check("t5_stall_c", {31'b0, stall}, 32'h1);
    step();
    check("t5_addr", mif.mem_addr, 32'h40);
    check("t5_req", {31'b0, mif.mem_req}, 32'h1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h41;
    step();
    mif.mem_ack = 1'b0; fetch = 1'b0;
    check("t5_mbr", {24'b0, MBR}, 32'h41);

    // Fetch that matches the prefetch in its ack cycle
    pc_wr = 1'b1; pc_in = 32'h41; fetch = 1'b1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h33;
    #1;
    check("t5m_stall", {31'b0, stall}, 32'h0);
    step();
    pc_wr = 1'b0; fetch = 1'b0; mif.mem_ack = 1'b0;
    check("t5m_mbr", {24'b0, MBR}, 32'h33);
`endif

    // Fetch at the top of the address space
    pc_wr = 1'b1; pc_in = 32'hFFFFFFFF; fetch = 1'b1;
    step();
    pc_wr = 1'b0;
    check("t6_addr", mif.mem_addr, 32'hFFFFFFFF);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h01;
    step();
    mif.mem_ack = 1'b0; fetch = 1'b0;
    check("t6_mbr", {24'b0, MBR}, 32'h01);
    check("t6_zext", mbr_zext, 32'h00000001);
`ifdef FETCH_PREFETCH_EN
    check("t6_wrap_addr", mif.mem_addr, 32'h0);
    check("t6_wrap_req", {31'b0, mif.mem_req}, 32'h1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h02;
    step();
    mif.mem_ack = 1'b0;
`else
    check("t6_req", {31'b0, mif.mem_req}, 32'h0);
    // Stray ack while idle must be ignored
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'hEE;
    step();
    mif.mem_ack = 1'b0;
    check("t6_stray_mbr", {24'b0, MBR}, 32'h01);
    check("t6_stray_req", {31'b0, mif.mem_req}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
